// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART transmit path.
//   - tx_state_t : state encoding of the byte-level transmit sequencer
//   - LINE_IDLE / START_LEVEL / STOP_LEVEL : serial line levels
//   - frame_len() : number of bits in one frame (start + data + parity + stops)
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_NEXT      = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Frame length in bits; fits the 4-bit bit index (max 1 + 8 + 1 + 2 = 12).
  function automatic logic [3:0] frame_len(input int data_bits,
                                           input int parity_enable,
                                           input int stop_bits);
    return 4'(1 + data_bits + ((parity_enable != 0) ? 1 : 0) + stop_bits);
  endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
//   Byte-level UART transmit sequencer. Takes one word over a valid/ready
//   handshake and walks the frame (start, data LSB-first, optional parity,
//   stop bit(s)) out one bit at a time to the single-bit transmit stage.
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous, active-high; aborts any frame in progress
//   data        word to send, sampled only on accept
//   dataValid   upstream has a word
//   dataReady   sequencer can accept a word (idle and bit stage idle)
//   busy        frame in progress
//   frameDone   one-cycle pulse when the last stop bit completes
//   bitStart    one-cycle start pulse per bit, to the bit stage
//   bitValue    level of the current bit, held for the whole bit
//   bitDone     bit stage done/idle flag (1 = idle)
//   debugState  current sequencer state, for observation only
//
// Handshake: a word transfers on a rising edge where dataValid and dataReady
// are both 1. Upstream must hold data/dataValid stable until that edge;
// dataValid while dataReady is 0 is simply not consumed.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DataBits     = 8,
  parameter int StopBits     = 1,
  parameter int ParityEnable = 0,
  parameter int ParityOdd    = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DataBits-1:0] data,
  input  logic                dataValid,
  output logic                dataReady,
  output logic                busy,
  output logic                frameDone,
  output logic                bitStart,
  output logic                bitValue,
  input  logic                bitDone,
  output tx_state_t           debugState
);

  localparam logic [3:0] LAST_INDEX = frame_len(DataBits, ParityEnable, StopBits) - 4'd1;
  localparam logic [3:0] DATA_IDX   = 4'(DataBits);
  localparam logic       PARITY_ON  = (ParityEnable != 0);
  localparam logic       PARITY_ODD = (ParityOdd != 0);

  tx_state_t           state;
  logic [DataBits-1:0] shiftReg;
  logic                parityBit;
  logic [3:0]          bitIndex;

  assign debugState = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      dataReady <= 1'b1;
      busy      <= 1'b0;
      frameDone <= 1'b0;
      bitStart  <= 1'b0;
      bitValue  <= LINE_IDLE;
      shiftReg  <= '0;
      parityBit <= 1'b0;
      bitIndex  <= '0;
    end else begin
      frameDone <= 1'b0;
      bitStart  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dataValid && dataReady) begin
            shiftReg  <= data;
            parityBit <= (^data) ^ PARITY_ODD;
            bitIndex  <= '0;
            dataReady <= 1'b0;
            busy      <= 1'b1;
            bitValue  <= START_LEVEL;
            bitStart  <= 1'b1;
            state     <= S_ISSUE;
          end else begin
            // A bit stage still finishing its last bit blocks acceptance.
            dataReady <= bitDone;
          end
        end

        S_ISSUE: begin
          state <= S_WAIT_BUSY;
        end

        // The bit stage may still show done=1 for a cycle after the start
        // pulse, so only a 0 here proves it has taken the bit.
        S_WAIT_BUSY: begin
          if (!bitDone) state <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          if (bitDone) state <= S_NEXT;
        end

        S_NEXT: begin
          if (bitIndex == LAST_INDEX) begin
            frameDone <= 1'b1;
            bitValue  <= LINE_IDLE;
            busy      <= 1'b0;
            dataReady <= 1'b1;
            state     <= S_IDLE;
          end else begin
            bitIndex <= bitIndex + 4'd1;
            bitStart <= 1'b1;
            state    <= S_ISSUE;
            // Select the level of bit (bitIndex + 1).
            if (bitIndex < DATA_IDX) begin
              bitValue <= shiftReg[0];
              shiftReg <= shiftReg >> 1;
            end else if (PARITY_ON && (bitIndex == DATA_IDX)) begin
              bitValue <= parityBit;
            end else begin
              bitValue <= STOP_LEVEL;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame
//   Four sequencer instances (default, even parity, odd parity, two stop bits),
//   each paired with a behavioural bit stage of 10 clocks per bit. Expected
//   line bits come from a frame model; per-cycle checks run on the falling edge.
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int NI       = 4;
  localparam int BIT_CLKS = 10;
  localparam int TIMEOUT  = 600;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  // ---------------- DUT signals ----------------
  logic [7:0] data      [NI];
  logic       dataValid [NI];
  logic       dataReady [NI];
  logic       busy      [NI];
  logic       frameDone [NI];
  logic       bitStart  [NI];
  logic       bitValue  [NI];
  logic       bitDone   [NI];
  tx_state_t  debugState[NI];

  // instance configuration, used only by the frame model
  int cfg_par  [NI] = '{0, 1, 1, 0};
  int cfg_odd  [NI] = '{0, 0, 1, 0};
  int cfg_stop [NI] = '{1, 1, 1, 2};

  uart_tx_frame #(.DataBits(8), .StopBits(1), .ParityEnable(0), .ParityOdd(0)) u_frame0 (
    .clock(clock), .reset(reset), .data(data[0]), .dataValid(dataValid[0]),
    .dataReady(dataReady[0]), .busy(busy[0]), .frameDone(frameDone[0]),
    .bitStart(bitStart[0]), .bitValue(bitValue[0]), .bitDone(bitDone[0]),
    .debugState(debugState[0]));

  uart_tx_frame #(.DataBits(8), .StopBits(1), .ParityEnable(1), .ParityOdd(0)) u_frame1 (
    .clock(clock), .reset(reset), .data(data[1]), .dataValid(dataValid[1]),
    .dataReady(dataReady[1]), .busy(busy[1]), .frameDone(frameDone[1]),
    .bitStart(bitStart[1]), .bitValue(bitValue[1]), .bitDone(bitDone[1]),
    .debugState(debugState[1]));

  uart_tx_frame #(.DataBits(8), .StopBits(1), .ParityEnable(1), .ParityOdd(1)) u_frame2 (
    .clock(clock), .reset(reset), .data(data[2]), .dataValid(dataValid[2]),
    .dataReady(dataReady[2]), .busy(busy[2]), .frameDone(frameDone[2]),
    .bitStart(bitStart[2]), .bitValue(bitValue[2]), .bitDone(bitDone[2]),
    .debugState(debugState[2]));

  uart_tx_frame #(.DataBits(8), .StopBits(2), .ParityEnable(0), .ParityOdd(0)) u_frame3 (
    .clock(clock), .reset(reset), .data(data[3]), .dataValid(dataValid[3]),
    .dataReady(dataReady[3]), .busy(busy[3]), .frameDone(frameDone[3]),
    .bitStart(bitStart[3]), .bitValue(bitValue[3]), .bitDone(bitDone[3]),
    .debugState(debugState[3]));

  // ---------------- behavioural bit stage ----------------
  // Takes a start pulse when idle, keeps done=1 one extra cycle, then holds
  // done=0 until the bit period ends. tx follows bitValue while active.
  int   bs_cnt [NI];
  logic tx     [NI];

  always @(posedge clock or posedge reset) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        bs_cnt[i]  <= 0;
        bitDone[i] <= 1'b1;
        tx[i]      <= 1'b1;
      end else if (bs_cnt[i] == 0) begin
        if (bitStart[i]) begin
          bs_cnt[i] <= BIT_CLKS;
          tx[i]     <= bitValue[i];
        end
      end else begin
        bs_cnt[i]  <= bs_cnt[i] - 1;
        tx[i]      <= bitValue[i];
        bitDone[i] <= (bs_cnt[i] == 1);
      end
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  logic [0:0]  exp_q  [NI][$];   // expected line bits, in send order
  logic [19:0] done_q [NI][$];   // completed frames: {bit count, bits}
  int          accepts         [NI];
  int          dones           [NI];
  int          accept_cycle    [NI];
  int          last_done_cycle [NI];
  logic [15:0] obs_bits        [NI];
  int          obs_n           [NI];
  logic        prev_start      [NI];
  int          start_pulses = 0;
  logic        eb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: start, data LSB first, parity, stop bits.
  task automatic push_frame(input int i, input logic [7:0] word);
    logic p;
    p = (cfg_odd[i] != 0);
    exp_q[i].push_back(1'b0);
    for (int k = 0; k < 8; k++) begin
      exp_q[i].push_back(word[k]);
      p = p ^ word[k];
    end
    if (cfg_par[i] != 0) exp_q[i].push_back(p);
    for (int k = 0; k < cfg_stop[i]; k++) exp_q[i].push_back(1'b1);
  endtask

  // Compare process.
  always @(negedge clock) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        exp_q[i].delete();
        obs_bits[i]   = '0;
        obs_n[i]      = 0;
        dones[i]      = accepts[i];
        prev_start[i] = 1'b0;
      end else begin
        if (bs_cnt[i] == BIT_CLKS / 2) begin
          obs_bits[i] = {obs_bits[i][14:0], tx[i]};
          obs_n[i]++;
          check($sformatf("bit_expected_u%0d", i), 32'(exp_q[i].size() != 0), 1);
          if (exp_q[i].size() != 0)
            check($sformatf("tx_bit_u%0d", i), 32'(tx[i]), 32'(exp_q[i].pop_front()));
        end
        if (frameDone[i]) begin
          check($sformatf("done_in_frame_u%0d", i), 32'(accepts[i] != dones[i]), 1);
          check($sformatf("done_all_bits_u%0d", i), exp_q[i].size(), 0);
          done_q[i].push_back({4'(obs_n[i]), obs_bits[i]});
          obs_bits[i] = '0;
          obs_n[i]    = 0;
          dones[i]++;
          last_done_cycle[i] = cycle;
        end
        eb = (accepts[i] != dones[i]);
        check($sformatf("busy_u%0d", i), 32'(busy[i]), 32'(eb));
        check($sformatf("ready_u%0d", i), 32'(dataReady[i]), 32'(!eb));
        if (bitStart[i]) begin
          start_pulses++;
          check($sformatf("start_in_frame_u%0d", i), 32'(eb), 1);
          check($sformatf("start_stage_idle_u%0d", i), 32'(bitDone[i]), 1);
          check($sformatf("start_single_u%0d", i), 32'(prev_start[i]), 0);
        end
        if (!eb) check($sformatf("idle_line_u%0d", i), 32'(tx[i]), 1);
        prev_start[i] = bitStart[i];
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents a word and holds it until accepted; leaves dataValid high.
  task automatic send(input int i, input logic [7:0] word);
    int waited;
    waited = 0;
    @(negedge clock);
    data[i]      = word;
    dataValid[i] = 1'b1;
    while (!dataReady[i] && waited < TIMEOUT) begin
      @(negedge clock);
      waited++;
    end
    check($sformatf("accept_wait_u%0d", i), 32'(waited < TIMEOUT), 1);
    @(posedge clock);
    #1;
    accept_cycle[i] = cycle;
    accepts[i]++;
    push_frame(i, word);
  endtask

  task automatic expect_frame(input int i, input string name, input int n,
                              input logic [15:0] bits, output logic [15:0] got);
    int waited;
    logic [19:0] rec;
    waited = 0;
    got = '0;
    while (done_q[i].size() == 0 && waited < TIMEOUT) begin
      @(posedge clock);
      waited++;
    end
    check({name, "_done"}, 32'(done_q[i].size() != 0), 1);
    if (done_q[i].size() != 0) begin
      rec = done_q[i].pop_front();
      check({name, "_len"}, 32'(rec[19:16]), 32'(n));
      check({name, "_bits"}, 32'(rec[15:0]), 32'(bits));
      got = rec[15:0];
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_ready_u%0d", tag, i), 32'(dataReady[i]), 1);
      check($sformatf("%s_busy_u%0d", tag, i), 32'(busy[i]), 0);
      check($sformatf("%s_done_u%0d", tag, i), 32'(frameDone[i]), 0);
      check($sformatf("%s_start_u%0d", tag, i), 32'(bitStart[i]), 0);
      check($sformatf("%s_value_u%0d", tag, i), 32'(bitValue[i]), 1);
      check($sformatf("%s_tx_u%0d", tag, i), 32'(tx[i]), 1);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [15:0] got;
  int zeros;
  int waited5;

  initial begin
    for (int i = 0; i < NI; i++) begin
      data[i] = '0; dataValid[i] = 1'b0;
      accepts[i] = 0; dones[i] = 0;
      accept_cycle[i] = 0; last_done_cycle[i] = 0;
      obs_bits[i] = '0; obs_n[i] = 0; prev_start[i] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_values("por");
    reset = 1'b0;

    // Idle after reset release: no starts, line high, no frameDone.
    repeat (100) @(negedge clock);
    check("idle_start_pulses", start_pulses, 0);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("idle_frames_u%0d", i), done_q[i].size(), 0);
      check($sformatf("idle_tx_u%0d", i), 32'(tx[i]), 1);
    end

    // Default configuration, 0xA5.
    send(0, 8'hA5);
    dataValid[0] = 1'b0;
    expect_frame(0, "t1_a5", 10, 16'b0101001011, got);
    repeat (30) @(negedge clock);
    check("t1_single_done", done_q[0].size(), 0);

    // Even and odd parity, 0xA5.
    send(1, 8'hA5);
    dataValid[1] = 1'b0;
    send(2, 8'hA5);
    dataValid[2] = 1'b0;
    expect_frame(1, "t2_even", 11, 16'b01010010101, got);
    check("t2_even_parity", 32'(got[1]), 0);
    expect_frame(2, "t2_odd", 11, 16'b01010010111, got);
    check("t2_odd_parity", 32'(got[1]), 1);

    // Two stop bits, 0x00: line low for exactly 9 bit periods.
    send(3, 8'h00);
    dataValid[3] = 1'b0;
    expect_frame(3, "t3_stop2", 11, 16'b00000000011, got);
    zeros = 0;
    for (int k = 0; k < 11; k++) if (!got[k]) zeros++;
    check("t3_low_bits", zeros, 9);

    // Back-to-back with dataValid held; data changes mid-frame.
    send(0, 8'h3C);
    data[0] = 8'hC3;
    send(0, 8'hC3);
    dataValid[0] = 1'b0;
    check("t4_accept_gap", accept_cycle[0], last_done_cycle[0] + 1);
    repeat (40) @(negedge clock);
    data[0] = 8'h00;
    expect_frame(0, "t4_first", 10, 16'b0001111001, got);
    expect_frame(0, "t4_second", 10, 16'b0110000111, got);

    // Reset during data bit 4, then a clean 0x55.
    send(0, 8'hFF);
    dataValid[0] = 1'b0;
    waited5 = 0;
    while (obs_n[0] < 6 && waited5 < TIMEOUT) begin
      @(posedge clock);
      waited5++;
    end
    check("t5_reach_bit4", 32'(obs_n[0] >= 6), 1);
    #3;
    reset = 1'b1;
    #1;
    check_reset_values("mid");
    repeat (3) @(negedge clock);
    reset = 1'b0;
    send(0, 8'h55);
    dataValid[0] = 1'b0;
    expect_frame(0, "t5_55", 10, 16'b0101010101, got);

    repeat (30) @(negedge clock);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("end_exp_empty_u%0d", i), exp_q[i].size(), 0);
      check($sformatf("end_no_extra_u%0d", i), done_q[i].size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
